// File: rtl/wb_reg_file.sv
// rtl/wb_reg_file.sv - 32x32 write-back register file with write-through bypass and commit counter
module wb_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic [31:0] read_data_in,
    input  logic [31:0] ALU_result_in,
    input  logic [4:0]  mux_reg_dst_out_in,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [31:0] write_data_out,
    output logic        wb_active_out,
    output logic [31:0] retire_count
);

    logic [31:0] regs [32];

    assign write_data_out = mem_to_reg_in ? read_data_in : ALU_result_in;
    assign wb_active_out  = reg_write_in && (mux_reg_dst_out_in != 5'd0);

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
            retire_count <= 32'h0;
        end else if (wb_active_out) begin
            regs[mux_reg_dst_out_in] <= write_data_out;
            retire_count             <= retire_count + 32'd1;
        end
    end

    // Bypass lets the ID stage see a value committing in this same cycle.
    always_comb begin
        read_data1 = 32'h0;
        if (read_reg1 != 5'd0) begin
            if (wb_active_out && (read_reg1 == mux_reg_dst_out_in)) begin
                read_data1 = write_data_out;
            end else begin
                read_data1 = regs[read_reg1];
            end
        end
    end

    always_comb begin
        read_data2 = 32'h0;
        if (read_reg2 != 5'd0) begin
            if (wb_active_out && (read_reg2 == mux_reg_dst_out_in)) begin
                read_data2 = write_data_out;
            end else begin
                read_data2 = regs[read_reg2];
            end
        end
    end

endmodule

// File: doc/wb_reg_file.md
WB_REG_FILE -- requirements
Module: wb_reg_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- reg_write_in  input  1  write-back enable from the MEM/WB stage.
- mem_to_reg_in  input  1  1 = write memory load data, 0 = write ALU result.
- read_data_in  input  32  memory load data from the MEM/WB stage.
- ALU_result_in  input  32  ALU result from the MEM/WB stage.
- mux_reg_dst_out_in  input  5  destination register index.
- read_reg1  input  5  source index, port 1 (ID stage).
- read_reg2  input  5  source index, port 2 (ID stage).
- read_data1  output  32  register value, port 1.
- read_data2  output  32  register value, port 2.
- write_data_out  output  32  selected write-back value, for EX-stage forwarding.
- wb_active_out  output  1  a committing write is in progress this cycle.
- retire_count  output  32  number of committed register writes.

Function
REQ-003 The block SHALL compute write_data_out combinationally: read_data_in when mem_to_reg_in=1, otherwise ALU_result_in.
REQ-004 The block SHALL hold 32 registers of 32 bits each, indexed 0-31.
REQ-005 Register 0 SHALL always read as 0x00000000; writes to it SHALL be discarded.
REQ-006 wb_active_out SHALL be combinational and equal reg_write_in AND (mux_reg_dst_out_in != 0).
REQ-007 On a rising clk edge with rst=0 and wb_active_out=1, the block SHALL load write_data_out into register[mux_reg_dst_out_in].
- Write latency: 1 edge.
REQ-008 When wb_active_out=0, register contents SHALL remain unchanged.
REQ-009 read_data1 and read_data2 SHALL be combinational; the two ports SHALL be independent and may address the same register.
REQ-010 Same-cycle write bypass (write-through): when a read port index is non-zero, equals mux_reg_dst_out_in, and wb_active_out=1, that port SHALL output write_data_out instead of the stored value.
- This removes the need for a WB-to-ID hazard stall.
REQ-011 Otherwise, each read port SHALL output the stored value of the addressed register.
REQ-012 retire_count SHALL increment by 1 on every edge that commits a write (REQ-007).
- It SHALL wrap from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-013 Writes with reg_write_in=1 to register 0 SHALL NOT increment retire_count.
REQ-014 Changes to mem_to_reg_in, read_data_in or ALU_result_in while reg_write_in=0 SHALL have no effect on any state.

Reset
REQ-015 On a rising clk edge with rst=1, all 32 registers and retire_count SHALL become 0x00000000.
REQ-016 rst SHALL take priority over a simultaneous write; that write SHALL be lost and not counted.
REQ-017 Combinational outputs SHALL follow REQ-003, REQ-006 and REQ-010 while rst is asserted.
- With reg_write_in=0, read_data1/2 SHALL read 0 from the first edge after reset.
REQ-018 Before the first reset edge, register and counter contents are undefined; the bench SHALL apply rst for at least 1 cycle before checking.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Basic ALU write: rst 1 cycle; write dst=5, mem_to_reg=0, ALU_result=0x12345678 -> next cycle read_reg1=5 gives 0x12345678; retire_count=1.
- Load write: dst=7, mem_to_reg=1, read_data_in=0xDEADBEEF, ALU_result=0x1 -> register 7 = 0xDEADBEEF; write_data_out=0xDEADBEEF in the same cycle.
- Bypass: reg 3 holds 0xAAAA0000; in one cycle write dst=3 with 0x5555FFFF and read_reg1=read_reg2=3 -> both outputs show 0x5555FFFF in that cycle; stored value is 0x5555FFFF afterward.
- Zero register: write dst=0 with 0xFFFFFFFF -> read_reg1=0 gives 0 in that cycle and after; wb_active_out=0; retire_count unchanged.
- Reset mid-operation: rst=1 together with write dst=9, 0x0000CAFE -> register 9 = 0 and retire_count=0 after the edge.
- Counter wrap: force retire_count to 0xFFFFFFFF via 2^32-1 commits (or a hierarchical force); one more commit -> 0x00000000.
